// File: rtl/pg_alu_array.sv
// pg_alu_array: multi-lane ALU, each lane in its own power domain with
// an ON -> ISO -> OFF -> WAKE gating sequencer and valid/ready input.
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   force_on          global override: blocks gating, wakes non-ON lanes
//   in_valid/in_ready per-lane request handshake (ready only while ON)
//   op, a, b          per-lane op [3i+2:3i], operands [W*i+W-1:W*i]
//   out_valid, result per-lane registered result and one-cycle valid
//   power_enable      per-lane power-switch enable
//   iso_en            per-lane output isolation enable
//
// Build option: PG_RETENTION_EN keeps the result register through
// gating and clamps the isolated output to it; otherwise the result
// clears on ISO->OFF and the isolated output clamps to 0.
module pg_alu_array #(
    parameter int WIDTH    = 8,
    parameter int LANES    = 2,
    parameter int IDLE_TH  = 3,
    parameter int WAKE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   force_on,
    input  logic [LANES-1:0]       in_valid,
    output logic [LANES-1:0]       in_ready,
    input  logic [3*LANES-1:0]     op,
    input  logic [WIDTH*LANES-1:0] a,
    input  logic [WIDTH*LANES-1:0] b,
    output logic [LANES-1:0]       out_valid,
    output logic [WIDTH*LANES-1:0] result,
    output logic [LANES-1:0]       power_enable,
    output logic [LANES-1:0]       iso_en
);

    typedef enum logic [1:0] {
        ST_ON,
        ST_ISO,
        ST_OFF,
        ST_WAKE
    } pg_state_t;

    localparam int IW = $clog2(IDLE_TH + 1);
    localparam int WW = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TH - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
    localparam logic [WW-1:0] WAKE_INIT = WW'(WAKE_LAT - 1);
    localparam logic [WW-1:0] WAKE_ONE  = WW'(1);

`ifdef PG_RETENTION_EN
    localparam bit RETAIN = 1'b1;
`else
    localparam bit RETAIN = 1'b0;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [2:0]       l_op;
        logic [WIDTH-1:0] l_a;
        logic [WIDTH-1:0] l_b;
        logic [WIDTH-1:0] alu_y;
        logic [WIDTH-1:0] res_q;
        logic             ov_q;
        logic             active;
        pg_state_t        st_q;
        pg_state_t        st_d;
        logic [IW-1:0]    idle_q;
        logic [IW-1:0]    idle_d;
        logic [WW-1:0]    wake_q;
        logic [WW-1:0]    wake_d;

        assign l_op = op[3*i +: 3];
        assign l_a  = a[WIDTH*i +: WIDTH];
        assign l_b  = b[WIDTH*i +: WIDTH];

        // Only a non-NOP accepted while ON counts as activity.
        assign active = in_valid[i] && (st_q == ST_ON) && (l_op != 3'd0);

        always_comb begin
            alu_y = '0;
            case (l_op)
                3'd1:    alu_y = l_a + l_b;
                3'd2:    alu_y = l_a - l_b;
                3'd3:    alu_y = l_a & l_b;
                3'd4:    alu_y = l_a | l_b;
                3'd5:    alu_y = l_a ^ l_b;
                3'd6:    alu_y = l_a << 1;
                3'd7:    alu_y = l_a >> 1;
                default: alu_y = '0;
            endcase
        end

        always_comb begin
            st_d   = st_q;
            idle_d = idle_q;
            wake_d = wake_q;
            case (st_q)
                ST_ON: begin
                    if (force_on || active) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_LAST) begin
                        st_d = ST_ISO;
                    end else if (idle_q != '1) begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end
                ST_ISO: begin
                    st_d = ST_OFF;
                end
                ST_OFF: begin
                    // NOP requests deliberately do not wake the lane.
                    if ((in_valid[i] && (l_op != 3'd0)) || force_on) begin
                        st_d   = ST_WAKE;
                        wake_d = WAKE_INIT;
                    end
                end
                ST_WAKE: begin
                    if (wake_q == '0) begin
                        st_d   = ST_ON;
                        idle_d = '0;
                    end else begin
                        wake_d = wake_q - WAKE_ONE;
                    end
                end
                default: begin
                    st_d = ST_ON;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st_q   <= ST_ON;
                idle_q <= '0;
                wake_q <= '0;
            end else begin
                st_q   <= st_d;
                idle_q <= idle_d;
                wake_q <= wake_d;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                res_q <= '0;
                ov_q  <= 1'b0;
            end else begin
                ov_q <= active;
                if (active) begin
                    res_q <= alu_y;
                end else if (st_q == ST_ISO && !RETAIN) begin
                    res_q <= '0;
                end
            end
        end

        assign in_ready[i]     = (st_q == ST_ON);
        assign power_enable[i] = (st_q != ST_OFF);
        assign iso_en[i]       = (st_q != ST_ON);
        assign out_valid[i]    = ov_q;

        // Isolated output clamps to the retained value or to zero.
        assign result[WIDTH*i +: WIDTH] =
            (iso_en[i] && !RETAIN) ? '0 : res_q;
    end

endmodule

// File: tb/tb_pg_alu_array.sv
// tb_pg_alu_array: directed + randomized bench for pg_alu_array,
// checked every cycle against a behavioural lane model.
module tb_pg_alu_array;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int TH = 3;
    localparam int WL = 2;
    localparam int M  = 1 << W;

`ifdef PG_RETENTION_EN
    localparam bit RET = 1'b1;
`else
    localparam bit RET = 1'b0;
`endif

    // Model lane phases: 0 powered, 1 isolating, 2 off, 3 ramping.
    localparam int P_ON   = 0;
    localparam int P_ISO  = 1;
    localparam int P_OFF  = 2;
    localparam int P_WAKE = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             force_on = 1'b0;
    logic [L-1:0]     in_valid = '0;
    logic [L-1:0]     in_ready;
    logic [3*L-1:0]   op = '0;
    logic [W*L-1:0]   a = '0;
    logic [W*L-1:0]   b = '0;
    logic [L-1:0]     out_valid;
    logic [W*L-1:0]   result;
    logic [L-1:0]     power_enable;
    logic [L-1:0]     iso_en;

    int passed = 0;
    int total  = 0;

    int m_phase [L];
    int m_idle  [L];
    int m_wake  [L];
    int m_res   [L];
    bit m_ov    [L];

    pg_alu_array #(
        .WIDTH(W), .LANES(L), .IDLE_TH(TH), .WAKE_LAT(WL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .force_on(force_on),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .result(result),
        .power_enable(power_enable), .iso_en(iso_en)
    );

    always #5 clk = ~clk;

    function automatic int alu(int o, int x, int y);
        case (o)
            1: return (x + y) % M;
            2: return (x - y + M) % M;
            3: return x & y;
            4: return x | y;
            5: return x ^ y;
            6: return (x * 2) % M;
            7: return x / 2;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, int got, int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            m_phase[i] = P_ON;
            m_idle[i]  = 0;
            m_wake[i]  = 0;
            m_res[i]   = 0;
            m_ov[i]    = 0;
        end
    endtask

    // Advance the model by one clock using the inputs now applied.
    task automatic model_step();
        for (int i = 0; i < L; i++) begin
            int o;
            bit req;
            bit act;
            o   = int'(op[3*i +: 3]);
            req = in_valid[i];
            act = req && (m_phase[i] == P_ON) && (o != 0);
            m_ov[i] = act;
            if (act) m_res[i] = alu(o, int'(a[W*i +: W]), int'(b[W*i +: W]));
            case (m_phase[i])
                P_ON: begin
                    if (act || force_on) m_idle[i] = 0;
                    else if (m_idle[i] + 1 == TH) m_phase[i] = P_ISO;
                    else m_idle[i]++;
                end
                P_ISO: begin
                    m_phase[i] = P_OFF;
                    if (!RET) m_res[i] = 0;
                end
                P_OFF: begin
                    if ((req && o != 0) || force_on) begin
                        m_phase[i] = P_WAKE;
                        m_wake[i]  = WL;
                    end
                end
                default: begin
                    m_wake[i]--;
                    if (m_wake[i] == 0) begin
                        m_phase[i] = P_ON;
                        m_idle[i]  = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < L; i++) begin
            bit iso;
            int er;
            iso = (m_phase[i] != P_ON);
            er  = (iso && !RET) ? 0 : m_res[i];
            chk($sformatf("ready%0d", i), int'(in_ready[i]),
                int'(m_phase[i] == P_ON));
            chk($sformatf("pwr%0d", i), int'(power_enable[i]),
                int'(m_phase[i] != P_OFF));
            chk($sformatf("iso%0d", i), int'(iso_en[i]), int'(iso));
            chk($sformatf("ovld%0d", i), int'(out_valid[i]), int'(m_ov[i]));
            chk($sformatf("res%0d", i), int'(result[W*i +: W]), er);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(int i, bit v, int o, int x, int y);
        in_valid[i]     = v;
        op[3*i +: 3]    = 3'(o);
        a[W*i +: W]     = W'(x);
        b[W*i +: W]     = W'(y);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_ready", int'(in_ready), 3);
        chk("rst_res", int'(result), 0);
        reset_n = 1'b1;

        // Basic add on lane 0 only.
        drive(0, 1, 1, 'hF0, 'h20);
        cycle();
        chk("add_ov0", int'(out_valid[0]), 1);
        chk("add_res0", int'(result[7:0]), 'h10);
        chk("add_ov1", int'(out_valid[1]), 0);

        // Lane 1 idle since cycle 0: ISO at cycle 3, OFF at cycle 4.
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("gate_iso1", int'(iso_en[1]), 1);
        chk("gate_pwr_iso1", int'(power_enable[1]), 1);
        cycle();
        chk("gate_pwr1", int'(power_enable[1]), 0);
        chk("gate_rdy1", int'(in_ready[1]), 0);
        repeat (2) cycle();
        chk("gate_pwr0", int'(power_enable[0]), 0);

        // Wake lane 0 with held XOR; NOP request on lane 1 keeps it off.
        drive(0, 1, 5, 'h0F, 'hFF);
        drive(1, 1, 0, 'h11, 'h22);
        n = 0;
        while (n < 10) begin
            cycle();
            n++;
            if (in_ready[0]) break;
        end
        chk("wake_lat", n, WL + 1);
        cycle();
        chk("wake_ov0", int'(out_valid[0]), 1);
        chk("wake_res0", int'(result[7:0]), 'hF0);
        chk("nop_off1", int'(power_enable[1]), 0);

        // Activity on the threshold cycle keeps lane 0 powered.
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(0, 1, 4, 'h30, 'h03);
        cycle();
        chk("thr_ready0", int'(in_ready[0]), 1);
        drive(0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("thr_restart0", int'(in_ready[0]), 1);

        // Held override: every lane ends up and stays powered.
        force_on = 1'b1;
        repeat (6) cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("force_ready", int'(in_ready), 3);
        end

        // Override raised during ISO: lane still passes OFF -> WAKE -> ON.
        force_on = 1'b0;
        repeat (3) cycle();
        chk("fiso_iso0", int'(iso_en[0]), 1);
        chk("fiso_pwr0", int'(power_enable[0]), 1);
        force_on = 1'b1;
        cycle();
        chk("fiso_off0", int'(power_enable[0]), 0);
        cycle();
        force_on = 1'b0;
        chk("fiso_wake0", int'({power_enable[0], iso_en[0], in_ready[0]}), 6);
        cycle();
        cycle();
        chk("fiso_on0", int'(in_ready[0]), 1);

        // Result 5A on lane 0, then gate it and look at the clamp.
        drive(0, 1, 5, 'h0F, 'h55);
        cycle();
        chk("ret_res0", int'(result[7:0]), 'h5A);
        drive(0, 0, 0, 0, 0);
        repeat (5) cycle();
        chk("ret_clamp0", int'(result[7:0]), RET ? 'h5A : 0);

        // Reset asserted while lane 0 is waking.
        drive(0, 1, 1, 1, 1);
        cycle();
        cycle();
        chk("rst_mid_iso", int'(iso_en[0]), 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rstw_ready", int'(in_ready), 3);
        chk("rstw_pwr", int'(power_enable), 3);
        chk("rstw_res", int'(result), 0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic; requests held while the lane is not ready.
        for (int t = 0; t < 400; t++) begin
            force_on = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < L; i++) begin
                if (!(in_valid[i] && m_phase[i] != P_ON)) begin
                    drive(i, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 7), $urandom_range(0, M - 1),
                          $urandom_range(0, M - 1));
                end
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
